cdm16_intc: RTL and testbench
=============================

Name: cdm16_intc

Overview:
- Interrupt controller that sits directly upstream of the cdm16 core.
- It collects up to N_SRC peripheral interrupt lines, latches them as pending, and masks them with a software enable register.
- It presents the highest-priority request on the core's in_irq/int_vec pins and consumes the core's IAck to retire the request.
- A small register port lets software enable, inspect, clear and trigger sources.

Parameters:
N_SRC, 8, number of interrupt sources (1..16); source 0 has the highest priority.
VEC_BASE, 6'd16, vector presented for source 0; source i presents VEC_BASE+i (VEC_BASE+N_SRC-1 must be <= 63).
EDGE_MASK, {N_SRC{1'b1}}, per-source mode: 1 = rising-edge latched, 0 = level.

Ports:
input_clock  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
irq_src  in  N_SRC  peripheral interrupt lines, synchronous to input_clock.
iack  in  1  interrupt acknowledge from the core (IAck).
irq  out  1  request to the core (in_irq).
int_vec  out  6  vector to the core (int_vec).
reg_addr  in  2  register select.
reg_wr  in  1  write strobe, one cycle per write.
reg_wdata  in  16  write data.
reg_rdata  out  16  read data, combinational from reg_addr.

Behaviour:
- Reset (asynchronous) sets:
  - pending=0, enable=0, src_prev=0
  - FSM=IDLE, irq=0, int_vec=0, vec_lat=0
  - reg_rdata follows reset register contents (addr 0 reads 0).
- Registers (unused high bits read 0, writes ignored):
  - addr 0 ENABLE: R/W, bits[N_SRC-1:0].
  - addr 1 PENDING: R; write-1-to-clear. W1C applies to edge sources only; level-source pending bits always equal irq_src.
  - addr 2 STATUS: R only.
    - bit15 = irq
    - bits[13:12] = FSM state (0 IDLE, 1 REQ, 2 ACK)
    - bits[5:0] = vec_lat
  - addr 3 SWTRIG: W only, reads 0. Writing 1 sets pending for edge sources; ignored for level sources.
- Edge pending update, per clock:
  - Set when irq_src[i]=1 and src_prev[i]=0, or on SWTRIG.
  - Cleared by W1C, or by acknowledge of source i.
  - Set wins over clear in the same cycle: an edge coinciding with an ack or a W1C leaves the bit pending.
  - src_prev <= irq_src every cycle.
- Request vector: req = pending & enable. sel = lowest index with req set.
- FSM:
  - IDLE: if req != 0, then vec_lat <= VEC_BASE+sel, src_lat <= sel, go to REQ. irq=0.
  - REQ: irq=1, int_vec=vec_lat, held stable.
    - No preemption: a higher-priority arrival does not change vec_lat.
    - If iack=1: clear pending[src_lat] (edge sources) and go to ACK.
    - Else if req[src_lat]=0 (masked, W1C'd, or level dropped): withdraw and go to IDLE.
    - iack takes priority over withdrawal in the same cycle.
  - ACK: irq=0, int_vec keeps vec_lat. Stay while iack=1 (iack may last several cycles under core hold). When iack=0, go to IDLE.
  - iack outside REQ is ignored and changes no state.
- int_vec is registered and equals vec_lat in REQ/ACK. It returns to 0 in IDLE only after reset; otherwise it keeps its last value (don't-care while irq=0).
- Latency:
  - Edge source: edge sampled at clock k, pending visible after k. REQ is entered at k+1, so irq is high 2 cycles after the edge.
  - Level source: irq is high 1 cycle after pending is set, because pending follows the input.
- Level source: an ack does not clear pending. After ACK->IDLE, a still-asserted line re-requests one cycle later.
- Reset mid-REQ/ACK: irq drops immediately (asynchronously); all pending is lost.
- reg writes to ENABLE take effect for the req computed in the next cycle.

Test Plan:
- Reset; ENABLE=0x0001; pulse irq_src[0] for 1 cycle -> PENDING=0x0001; irq=1 and int_vec=16 two cycles after the edge.
- Continuing: iack=1 for 3 cycles -> irq=0 the cycle after the first iack; PENDING=0; FSM stays ACK for 3 cycles, then IDLE; no re-request.
- ENABLE=0x00FF; raise src 5 and src 2 in the same cycle -> int_vec=18; after ack, int_vec=21; after the second ack, PENDING=0.
- In REQ for src 3 (vec 19), raise src 1 -> int_vec stays 19 until ack, then 17 is presented.
- In REQ for src 4, write ENABLE=0 with no iack -> irq falls, FSM=IDLE, PENDING bit 4 still 1.
- Same-cycle edge and W1C on edge src 6 -> bit stays set.
- Level src 7 (EDGE_MASK bit 7=0) held high, ack once -> irq re-asserts one cycle after ACK->IDLE.
- Assert reset while in REQ -> irq=0 with no clock edge; STATUS=0.

Source files
------------

// File: rtl/cdm16_intc.sv
// cdm16_intc: interrupt controller in front of the cdm16 core.
// Latches peripheral lines as pending, masks them with ENABLE, presents the
// highest-priority request as irq/int_vec and retires it on the core's iack.
module cdm16_intc #(
  parameter int               N_SRC     = 8,
  parameter logic [5:0]       VEC_BASE  = 6'd16,
  parameter logic [N_SRC-1:0] EDGE_MASK = {N_SRC{1'b1}}
) (
  input  logic             input_clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             iack,
  output logic             irq,
  output logic [5:0]       int_vec,
  input  logic [1:0]       reg_addr,
  input  logic             reg_wr,
  input  logic [15:0]      reg_wdata,
  output logic [15:0]      reg_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_PENDING = 2'd1;
  localparam logic [1:0] A_STATUS  = 2'd2;
  localparam logic [1:0] A_SWTRIG  = 2'd3;

  state_e           state_q, state_d;
  logic [5:0]       vec_lat_q, vec_lat_d;
  logic [3:0]       src_lat_q, src_lat_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] src_prev_q, src_prev_d;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] lat_mask;
  logic [N_SRC-1:0] set_mask;
  logic [N_SRC-1:0] clr_mask;
  logic [3:0]       sel;
  logic             ack_take;

  // High write-data bits beyond N_SRC carry no meaning for any register.
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata;

  // Masked request vector, lowest-index winner, and one-hot of the latched source.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    req      = pending_q & enable_q;
    sel      = '0;
    lat_mask = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) sel = 4'(i);
      if (src_lat_q == 4'(i)) lat_mask[i] = 1'b1;
    end
  end

  // FSM next state; the vector is latched once on IDLE->REQ, so no preemption.
  always_comb begin
    state_d   = state_q;
    vec_lat_d = vec_lat_q;
    src_lat_d = src_lat_q;
    ack_take  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          vec_lat_d = VEC_BASE + 6'(sel);
          src_lat_d = sel;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // iack beats withdrawal when both happen in the same cycle
        if (iack) begin
          ack_take = 1'b1;
          state_d  = ST_ACK;
        end else if (!(|(req & lat_mask))) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!iack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: irq only in REQ; int_vec is the registered latched vector.
  always_comb begin
    irq     = (state_q == ST_REQ);
    int_vec = vec_lat_q;
  end

  // Pending/enable next values; edge sets win over W1C and ack clears.
  always_comb begin
    set_mask = irq_src & ~src_prev_q;
    clr_mask = '0;
    enable_d = enable_q;
    if (reg_wr) begin
      case (reg_addr)
        A_ENABLE:  enable_d = reg_wdata[N_SRC-1:0];
        A_PENDING: clr_mask = reg_wdata[N_SRC-1:0];
        A_SWTRIG:  set_mask = set_mask | reg_wdata[N_SRC-1:0];
        default:   ;
      endcase
    end
    if (ack_take) clr_mask = clr_mask | lat_mask;
    // level sources simply track their input line
    pending_d  = (EDGE_MASK & (set_mask | (pending_q & ~clr_mask)))
               | (~EDGE_MASK & irq_src);
    src_prev_d = irq_src;
  end

  // Register read mux, combinational from reg_addr.
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      A_ENABLE:  reg_rdata[N_SRC-1:0] = enable_q;
      A_PENDING: reg_rdata[N_SRC-1:0] = pending_q;
      A_STATUS: begin
        reg_rdata[15]    = irq;
        reg_rdata[13:12] = state_q;
        reg_rdata[5:0]   = vec_lat_q;
      end
      default:   ;
    endcase
  end

  // FSM state register with latched vector and source index.
  always_ff @(posedge input_clock or posedge reset) begin
    // NOTE: asynchronous reset so irq drops the moment reset is asserted.
    if (reset) begin
      state_q   <= ST_IDLE;
      vec_lat_q <= '0;
      src_lat_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      vec_lat_q <= vec_lat_d;
      src_lat_q <= src_lat_d;
    end
  end

  // Pending, enable and edge-detect history registers.
  always_ff @(posedge input_clock or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      enable_q   <= '0;
      src_prev_q <= '0;
    end else begin
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      src_prev_q <= src_prev_d;
    end
  end

endmodule

// File: tb/tb_cdm16_intc.sv
// Testbench for cdm16_intc: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the controller.
module tb_cdm16_intc;

  localparam logic [7:0] EDGE = 8'h7F;  // source 7 is level-sensitive
  localparam int         VB   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic        iack;
  logic        irq;
  logic [5:0]  int_vec;
  logic [1:0]  reg_addr;
  logic        reg_wr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state: phase 0 idle, 1 requesting, 2 acknowledged.
  logic [7:0] m_pend, m_en, m_prev;
  int         m_phase, m_src;
  logic [5:0] m_vec;

  cdm16_intc #(
    .N_SRC    (8),
    .VEC_BASE (6'd16),
    .EDGE_MASK(EDGE)
  ) dut (
    .input_clock(clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .iack       (iack),
    .irq        (irq),
    .int_vec    (int_vec),
    .reg_addr   (reg_addr),
    .reg_wr     (reg_wr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {8'h00, m_en};
      2'd1:    return {8'h00, m_pend};
      2'd2:    return {(m_phase == 1), 1'b0, 2'(m_phase), 6'h00, m_vec};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_en    = '0;
    m_prev  = '0;
    m_phase = 0;
    m_src   = 0;
    m_vec   = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [7:0] req, np;
    logic       setb, clrb;
    req = m_pend & m_en;
    for (int i = 0; i < 8; i++) begin
      if (EDGE[i]) begin
        setb  = (irq_src[i] && !m_prev[i]) || (reg_wr && reg_addr == 2'd3 && reg_wdata[i]);
        clrb  = (reg_wr && reg_addr == 2'd1 && reg_wdata[i]) || (m_phase == 1 && iack && m_src == i);
        np[i] = setb ? 1'b1 : (clrb ? 1'b0 : m_pend[i]);
      end else begin
        np[i] = irq_src[i];
      end
    end
    case (m_phase)
      0: if (req != 0) begin
           for (int i = 7; i >= 0; i--) if (req[i]) m_src = i;
           m_vec   = 6'(VB + m_src);
           m_phase = 1;
         end
      1: if (iack) m_phase = 2;
         else if (!req[m_src]) m_phase = 0;
      2: if (!iack) m_phase = 0;
      default: ;
    endcase
    m_pend = np;
    m_prev = irq_src;
    if (reg_wr && reg_addr == 2'd0) m_en = reg_wdata[7:0];
  endtask

  // Compare outputs with the model, then advance one clock (returns at posedge+1).
  task automatic cycle();
    #1;
    check("irq", {15'd0, irq}, {15'd0, m_phase == 1});
    check("int_vec", {10'd0, int_vec}, {10'd0, m_vec});
    check("rdata", reg_rdata, model_read(reg_addr));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_wr    = 1'b1;
    cycle();
    reg_wr    = 1'b0;
    reg_addr  = 2'd2;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
    reg_addr = a;
    #1;
    check(tag, reg_rdata, exp);
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; iack = 1'b0;
    reg_addr = 2'd0; reg_wr = 1'b0; reg_wdata = '0;
    model_reset();
    #1;
    check("rst_irq", {15'd0, irq}, 16'd0);
    check("rst_vec", {10'd0, int_vec}, 16'd0);
    rd("rst_en", 2'd0, 16'h0000);
    rd("rst_pend", 2'd1, 16'h0000);
    @(posedge clk); #1;
    rd("rst_stat", 2'd2, 16'h0000);
    reset = 1'b0;
    cycle();

    // Single edge source 0, then a multi-cycle acknowledge
    wr_reg(2'd0, 16'h0001);
    irq_src = 8'h01; cycle(); irq_src = 8'h00;
    rd("t1_pend", 2'd1, 16'h0001);
    check("t1_irq_early", {15'd0, irq}, 16'd0);
    cycle();
    check("t1_irq", {15'd0, irq}, 16'd1);
    check("t1_vec", {10'd0, int_vec}, 16'd16);
    iack = 1'b1; cycle();
    check("t2_irq_ack", {15'd0, irq}, 16'd0);
    rd("t2_pend", 2'd1, 16'h0000);
    rd("t2_stat1", 2'd2, 16'h2010);
    cycle(); rd("t2_stat2", 2'd2, 16'h2010);
    cycle(); rd("t2_stat3", 2'd2, 16'h2010);
    iack = 1'b0; cycle();
    rd("t2_idle", 2'd2, 16'h0010);
    cycle(); cycle();
    check("t2_no_rereq", {15'd0, irq}, 16'd0);

    // Two simultaneous sources: priority order 2 then 5
    wr_reg(2'd0, 16'h00FF);
    irq_src = 8'h24; cycle(); irq_src = 8'h00; cycle();
    check("t3_vec_a", {10'd0, int_vec}, 16'd18);
    iack = 1'b1; cycle(); iack = 1'b0; cycle(); cycle();
    check("t3_vec_b", {10'd0, int_vec}, 16'd21);
    check("t3_irq_b", {15'd0, irq}, 16'd1);
    iack = 1'b1; cycle(); iack = 1'b0; cycle();
    rd("t3_pend", 2'd1, 16'h0000);

    // No preemption by a higher-priority arrival
    irq_src = 8'h08; cycle(); irq_src = 8'h00; cycle();
    irq_src = 8'h02; cycle(); irq_src = 8'h00; cycle();
    check("t4_hold_vec", {10'd0, int_vec}, 16'd19);
    check("t4_hold_irq", {15'd0, irq}, 16'd1);
    iack = 1'b1; cycle(); iack = 1'b0; cycle(); cycle();
    check("t4_next_vec", {10'd0, int_vec}, 16'd17);
    iack = 1'b1; cycle(); iack = 1'b0; cycle();

    // Withdrawal by masking while requesting
    irq_src = 8'h10; cycle(); irq_src = 8'h00; cycle();
    check("t5_vec", {10'd0, int_vec}, 16'd20);
    wr_reg(2'd0, 16'h0000);
    check("t5_irq_still", {15'd0, irq}, 16'd1);
    cycle();
    check("t5_irq_wd", {15'd0, irq}, 16'd0);
    rd("t5_stat", 2'd2, 16'h0014);
    rd("t5_pend", 2'd1, 16'h0010);
    wr_reg(2'd1, 16'h0010);
    rd("t5_w1c", 2'd1, 16'h0000);

    // Edge and W1C on the same cycle keep the bit; software trigger
    irq_src = 8'h40; cycle(); irq_src = 8'h00; cycle();
    irq_src = 8'h40; reg_addr = 2'd1; reg_wdata = 16'h0040; reg_wr = 1'b1;
    cycle();
    reg_wr = 1'b0; irq_src = 8'h00;
    rd("t6_set_wins", 2'd1, 16'h0040);
    wr_reg(2'd1, 16'h0040);
    rd("t6_cleared", 2'd1, 16'h0000);
    wr_reg(2'd3, 16'h0081);
    rd("t6_swtrig", 2'd1, 16'h0001);
    rd("t6_swtrig_rd", 2'd3, 16'h0000);
    wr_reg(2'd1, 16'h0001);
    rd("t6_final", 2'd1, 16'h0000);

    // Level source 7 held high re-requests after the acknowledge
    wr_reg(2'd0, 16'h0080);
    irq_src = 8'h80; cycle(); cycle();
    check("t7_irq", {15'd0, irq}, 16'd1);
    check("t7_vec", {10'd0, int_vec}, 16'd23);
    iack = 1'b1; cycle();
    check("t7_irq_ack", {15'd0, irq}, 16'd0);
    rd("t7_pend_kept", 2'd1, 16'h0080);
    iack = 1'b0; cycle();
    check("t7_idle_irq", {15'd0, irq}, 16'd0);
    rd("t7_idle", 2'd2, 16'h0017);
    cycle();
    check("t7_rereq", {15'd0, irq}, 16'd1);

    // Asynchronous reset while requesting
    reset = 1'b1; #1;
    check("t8_irq", {15'd0, irq}, 16'd0);
    rd("t8_stat", 2'd2, 16'h0000);
    rd("t8_pend", 2'd1, 16'h0000);
    check("t8_vec", {10'd0, int_vec}, 16'd0);
    irq_src = 8'h00; iack = 1'b0; reset = 1'b0;
    model_reset();
    cycle(); cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ (8'($urandom) & 8'($urandom));
      iack      = ($urandom_range(0, 2) == 0);
      reg_wr    = ($urandom_range(0, 5) == 0);
      reg_addr  = 2'($urandom);
      reg_wdata = 16'($urandom);
      cycle();
    end
    reg_wr = 1'b0; iack = 1'b0; irq_src = 8'h00;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
